// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder controller: FSM states and the
// bit-counter width helper.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The counter must reach WIDTH-1 without wrapping.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: feeds an external one-bit full adder LSB first,
// keeps the carry between bits and returns the assembled WIDTH-bit sum.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    output logic             fa_active,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output state_t           o_dbg_state
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_res_sh;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_shift;
    logic               w_done;

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready is high only in IDLE; out_valid only in DONE, and the result
    // is held unchanged until out_ready completes the transfer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid)           w_next_state = SHIFT;
            SHIFT:   if (r_cnt == LAST_BIT)  w_next_state = DONE;
            DONE:    if (out_ready)          w_next_state = IDLE;
            default:                         w_next_state = IDLE;
        endcase
    end

    assign w_shift     = (r_state == SHIFT);
    assign w_done      = (r_state == DONE);
    assign in_ready    = (r_state == IDLE);
    assign fa_active   = w_shift;
    assign o_dbg_state = r_state;

    // Shift registers drain to zero, so the operand bits are already 0 outside
    // SHIFT; the carry holds the final cout in DONE and must be masked.
    assign fa_a      = r_a_sh[0];
    assign fa_b      = r_b_sh[0];
    assign fa_cin    = r_carry & w_shift;

    assign out_valid = w_done;
    assign out_sum   = w_done ? r_res_sh : '0;
    assign out_cout  = w_done & r_carry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sh   <= in_a;
                        r_b_sh   <= in_b;
                        r_res_sh <= '0;
                        r_carry  <= in_cin;
                        r_cnt    <= '0;
                    end
                end
                SHIFT: begin
                    r_res_sh <= {fa_sum, r_res_sh[WIDTH-1:1]};
                    r_carry  <= fa_cout;
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl with a behavioural one-bit full adder attached
// to the fa_* ports; results are checked against a queue of expected sums.
module tb_serial_add_ctrl;
  import serial_add_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         fa_a;
  logic         fa_b;
  logic         fa_cin;
  logic         fa_active;
  logic         fa_sum;
  logic         fa_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  state_t       dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];

  // full adder stage
  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_active(fa_active),
    .fa_sum(fa_sum), .fa_cout(fa_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: present an operand pair, wait for in_ready, push the expected sum at accept
  task automatic do_accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int n;
    logic [W:0] e;
    n = 0;
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
    end
    tick();
    e = {1'b0, a} + {1'b0, b} + (W+1)'(c);
    exp_q.push_back(e);
    in_valid = 1'b0;
  endtask

  // driver: wait (bounded) for out_valid, recording fa_active cycles and the fa_cin trace
  task automatic wait_out(input bit jitter, output int cyc, output int act,
                          output logic [W-1:0] trace, output bit ok);
    cyc = 0; act = 0; trace = '0; ok = 1'b0;
    while (cyc < 40) begin
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (fa_active === 1'b1) act++;
      if (cyc < W) trace[cyc] = fa_cin;
      if (jitter) begin
        in_a = W'($urandom_range(0, (1 << W) - 1));
        in_b = W'($urandom_range(0, (1 << W) - 1));
      end
      tick();
      cyc++;
    end
  endtask

  function automatic logic [W-1:0] carry_trace(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic c);
    logic [W-1:0] t;
    logic cc;
    cc = c;
    for (int j = 0; j < W; j++) begin
      t[j] = cc;
      cc = (a[j] & b[j]) | (cc & (a[j] ^ b[j]));
    end
    return t;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    tick(); tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if ({out_cout, out_sum} !== '0) begin errors++; $display("FAIL rst_out got %h want 0", {out_cout, out_sum}); end
    checks++; if ({fa_a, fa_b, fa_cin, fa_active} !== 4'b0) begin errors++; $display("FAIL rst_fa got %b want 0000", {fa_a, fa_b, fa_cin, fa_active}); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state got %0d want IDLE", dbg_state); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int cyc, act;
    logic [W-1:0] tr;
    bit ok;
    logic [W:0] e;
    out_ready = 1'b1;
    do_accept(8'h0F, 8'h01, 1'b0);
    wait_out(1'b0, cyc, act, tr, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout out_valid=%b required 1", out_valid); end
    checks++; if (cyc != W) begin errors++; $display("FAIL basic_latency got %0d want %0d", cyc, W); end
    checks++; if (act != W) begin errors++; $display("FAIL basic_fa_active got %0d want %0d", act, W); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if ({out_cout, out_sum} !== e) begin errors++; $display("FAIL basic_sum got %h want %h", {out_cout, out_sum}, e); end
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_release got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
  endtask

  task automatic test_ripple_and_max();
    int cyc, act;
    logic [W-1:0] tr;
    bit ok;
    logic [W:0] e;
    out_ready = 1'b1;
    do_accept(8'hFF, 8'h01, 1'b0);
    wait_out(1'b0, cyc, act, tr, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ripple_timeout out_valid=%b required 1", out_valid); end
    checks++; if (tr !== carry_trace(8'hFF, 8'h01, 1'b0)) begin errors++; $display("FAIL ripple_fa_cin got %b want %b", tr, carry_trace(8'hFF, 8'h01, 1'b0)); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if ({out_cout, out_sum} !== e) begin errors++; $display("FAIL ripple_sum got %h want %h", {out_cout, out_sum}, e); end
    tick();
    do_accept(8'hFF, 8'hFF, 1'b1);
    wait_out(1'b0, cyc, act, tr, ok);
    checks++; if (!ok) begin errors++; $display("FAIL max_timeout out_valid=%b required 1", out_valid); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if ({out_cout, out_sum} !== e) begin errors++; $display("FAIL max_sum got %h want %h", {out_cout, out_sum}, e); end
    tick();
  endtask

  task automatic test_backpressure();
    int cyc, act;
    logic [W-1:0] tr;
    bit ok;
    logic [W:0] e;
    out_ready = 1'b0;
    do_accept(8'h12, 8'h34, 1'b1);
    wait_out(1'b0, cyc, act, tr, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout out_valid=%b required 1", out_valid); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || {out_cout, out_sum} !== e || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got v=%b r=%b sum=%h want v=1 r=0 sum=%h", i, out_valid, in_ready, {out_cout, out_sum}, e);
      end
      tick();
    end
    out_ready = 1'b1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_early got %b want 0", in_ready); end
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got r=%b v=%b want r=1 v=0", in_ready, out_valid); end
  endtask

  task automatic test_ignore_midop();
    int cyc, act;
    logic [W-1:0] tr;
    bit ok;
    logic [W:0] e;
    out_ready = 1'b1;
    do_accept(8'h3C, 8'h42, 1'b0);
    in_valid = 1'b1;
    wait_out(1'b1, cyc, act, tr, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ignore_timeout out_valid=%b required 1", out_valid); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if ({out_cout, out_sum} !== e) begin errors++; $display("FAIL ignore_sum got %h want %h", {out_cout, out_sum}, e); end
    in_a = 8'h11; in_b = 8'h22; in_cin = 1'b1;
    tick();
    checks++; if (dbg_state !== IDLE || in_ready !== 1'b1) begin errors++; $display("FAIL ignore_idle got state=%0d r=%b want IDLE r=1", dbg_state, in_ready); end
    do_accept(8'h11, 8'h22, 1'b1);
    wait_out(1'b0, cyc, act, tr, ok);
    checks++; if (!ok) begin errors++; $display("FAIL second_timeout out_valid=%b required 1", out_valid); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if ({out_cout, out_sum} !== e) begin errors++; $display("FAIL second_sum got %h want %h", {out_cout, out_sum}, e); end
    tick();
  endtask

  task automatic test_reset_midshift();
    int cyc, act;
    logic [W-1:0] tr;
    bit ok;
    logic [W:0] e;
    out_ready = 1'b1;
    do_accept(8'hAA, 8'h55, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || fa_active !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0) begin
      errors++;
      $display("FAIL midreset got v=%b act=%b r=%b sum=%h want v=0 act=0 r=1 sum=00", out_valid, fa_active, in_ready, out_sum);
    end
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    do_accept(8'h01, 8'h01, 1'b0);
    wait_out(1'b0, cyc, act, tr, ok);
    checks++; if (!ok) begin errors++; $display("FAIL postreset_timeout out_valid=%b required 1", out_valid); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if ({out_cout, out_sum} !== e) begin errors++; $display("FAIL postreset_sum got %h want %h", {out_cout, out_sum}, e); end
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc, act;
    logic [W-1:0] tr;
    bit ok;
    logic [W:0] e;
    logic [W-1:0] a, b;
    logic c;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = W'($urandom_range(0, (1 << W) - 1));
      b = W'($urandom_range(0, (1 << W) - 1));
      c = 1'($urandom_range(0, 1));
      do_accept(a, b, c);
      wait_out(1'b0, cyc, act, tr, ok);
      checks++;
      if (!ok || cyc != W) begin
        errors++;
        $display("FAIL b2b_latency[%0d] got %0d want %0d", i, cyc, W);
      end
      checks++;
      if (tr !== carry_trace(a, b, c)) begin
        errors++;
        $display("FAIL b2b_fa_cin[%0d] got %b want %b", i, tr, carry_trace(a, b, c));
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if ({out_cout, out_sum} !== e) begin
        errors++;
        $display("FAIL b2b_sum[%0d] got %h want %h", i, {out_cout, out_sum}, e);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ripple_and_max();
    test_backpressure();
    test_ignore_midop();
    test_reset_midshift();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
